// File: rtl/alu_uart_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_uart_sequencer
//  Description : Collects operand 1, operand 2 and opcode bytes from a UART
//                receiver, presents them to a combinational ALU, captures the
//                result and hands it to a UART transmitter through a
//                start/done handshake.
//                Optional inter-byte timeout: define SEQ_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_uart_sequencer #(
  parameter int BUS_LEN        = 8,
  parameter int OPCODE_LEN     = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUS_LEN-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  input  logic [BUS_LEN-1:0]    i_alu_result,
  output logic [BUS_LEN-1:0]    o_alu_ope1,
  output logic [BUS_LEN-1:0]    o_alu_ope2,
  output logic [OPCODE_LEN-1:0] o_alu_opcode,
  output logic [BUS_LEN-1:0]    o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_drop,
  output logic                  o_timeout
);

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_timeout_fire;
  logic                  w_expire;

  logic [BUS_LEN-1:0]    r_ope1;
  logic [BUS_LEN-1:0]    r_ope2;
  logic [OPCODE_LEN-1:0] r_opcode;
  logic [BUS_LEN-1:0]    r_tx_data;
  logic                  r_drop;
  logic                  r_timeout;

`ifdef SEQ_TIMEOUT_EN
  // Counter only has to reach TIMEOUT_CYCLES-1; the expiry edge is the next one.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             w_in_frame;

  assign w_in_frame = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
  assign w_expire   = w_in_frame && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Inter-byte cycle counter: runs only while a frame is partially received.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (w_accept || w_timeout_fire || !w_in_frame) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
  end
`else
  logic w_unused_timeout;

  assign w_expire         = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_WAIT_A;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; an arriving byte always beats a timeout expiry.
  always_comb begin
    w_state_next   = r_state;
    w_accept       = 1'b0;
    w_drop         = 1'b0;
    w_timeout_fire = 1'b0;
    case (r_state)
      ST_WAIT_A: begin
        if (i_rx_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_WAIT_OP;
        end else if (w_expire) begin
          w_timeout_fire = 1'b1;
          w_state_next   = ST_WAIT_A;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_EXEC;
        end else if (w_expire) begin
          w_timeout_fire = 1'b1;
          w_state_next   = ST_WAIT_A;
        end
      end
      ST_EXEC: begin
        w_drop       = i_rx_valid;
        w_state_next = ST_SEND;
      end
      ST_SEND: begin
        w_drop       = i_rx_valid;
        w_state_next = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        w_drop = i_rx_valid;
        if (i_tx_done) begin
          w_state_next = ST_WAIT_A;
        end
      end
      default: begin
        w_state_next = ST_WAIT_A;
      end
    endcase
  end

  // Operand and opcode latches; held until the next frame overwrites them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ope1   <= '0;
      r_ope2   <= '0;
      r_opcode <= '0;
    end else if (w_accept) begin
      case (r_state)
        ST_WAIT_A:  r_ope1   <= i_rx_data;
        ST_WAIT_B:  r_ope2   <= i_rx_data;
        ST_WAIT_OP: r_opcode <= i_rx_data[OPCODE_LEN-1:0];
        default:    r_ope1   <= r_ope1;
      endcase
    end
  end

  // Capture the settled ALU result at the end of the single EXEC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_data <= '0;
    end else if (r_state == ST_EXEC) begin
      r_tx_data <= i_alu_result;
    end
  end

  // Registered one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_drop    <= w_drop;
      r_timeout <= w_timeout_fire;
    end
  end

  assign o_alu_ope1   = r_ope1;
  assign o_alu_ope2   = r_ope2;
  assign o_alu_opcode = r_opcode;
  assign o_tx_data    = r_tx_data;
  // Decoded straight from the state register so the request cannot glitch.
  assign o_tx_start   = (r_state == ST_SEND);
  assign o_busy       = (r_state == ST_EXEC) || (r_state == ST_SEND) ||
                        (r_state == ST_WAIT_TX);
  assign o_drop       = r_drop;
  assign o_timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_alu_uart_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_uart_sequencer
//  Description : Self-checking bench for alu_uart_sequencer with a small
//                behavioural ALU attached. Timeout checks are compiled when
//                SEQ_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_uart_sequencer;

  localparam int BUS_LEN        = 8;
  localparam int OPCODE_LEN     = 6;
  localparam int TIMEOUT_CYCLES = 16;

  logic                  clk;
  logic                  rst;
  logic [BUS_LEN-1:0]    rx_data;
  logic                  rx_valid;
  logic [BUS_LEN-1:0]    alu_result;
  logic [BUS_LEN-1:0]    alu_ope1;
  logic [BUS_LEN-1:0]    alu_ope2;
  logic [OPCODE_LEN-1:0] alu_opcode;
  logic [BUS_LEN-1:0]    tx_data;
  logic                  tx_start;
  logic                  tx_done;
  logic                  busy;
  logic                  drop;
  logic                  timeout;

  int n_cmp = 0;
  int n_err = 0;

  alu_uart_sequencer #(
    .BUS_LEN        (BUS_LEN),
    .OPCODE_LEN     (OPCODE_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_alu_result (alu_result),
    .o_alu_ope1   (alu_ope1),
    .o_alu_ope2   (alu_ope2),
    .o_alu_opcode (alu_opcode),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .i_tx_done    (tx_done),
    .o_busy       (busy),
    .o_drop       (drop),
    .o_timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU standing in for the real one.
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      6'h20: alu_result = alu_ope1 + alu_ope2;
      6'h22: alu_result = alu_ope1 - alu_ope2;
      6'h24: alu_result = alu_ope1 & alu_ope2;
      6'h25: alu_result = alu_ope1 | alu_ope2;
      6'h26: alu_result = alu_ope1 ^ alu_ope2;
      6'h27: alu_result = ~(alu_ope1 | alu_ope2);
      6'h03: alu_result = $signed(alu_ope1) >>> alu_ope2;
      6'h02: alu_result = alu_ope1 >> alu_ope2;
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    logic [7:0] ope1;
    logic [7:0] ope2;
    logic [7:0] op_byte;
    logic [5:0] exp_opcode;
    logic [7:0] exp_result;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one byte for one cycle; returns at the negedge after it was sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Full frame with cycle-accurate checks of the EXEC/SEND/WAIT_TX sequence.
  task automatic run_frame(input vec_t v);
    send_byte(v.ope1);
    send_byte(v.ope2);
    send_byte(v.op_byte);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_no_start", 32'(tx_start), 32'd0);
    check("opcode", 32'(alu_opcode), 32'(v.exp_opcode));
    check("ope1", 32'(alu_ope1), 32'(v.ope1));
    check("ope2", 32'(alu_ope2), 32'(v.ope2));
    @(negedge clk);
    check("send_start", 32'(tx_start), 32'd1);
    check("tx_data", 32'(tx_data), 32'(v.exp_result));
    @(negedge clk);
    check("wait_tx_start_low", 32'(tx_start), 32'd0);
    check("wait_tx_busy", 32'(busy), 32'd1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int seen;
    rst      = 1'b1;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_done  = 1'b0;

    vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};  // ADD
    vecs[1] = '{8'h80, 8'h01, 8'h03, 6'h03, 8'hC0};  // SRA
    vecs[2] = '{8'hF0, 8'h3C, 8'hE4, 6'h24, 8'h30};  // AND, upper opcode bits ignored
    vecs[3] = '{8'h0F, 8'hF0, 8'h25, 6'h25, 8'hFF};  // OR
    vecs[4] = '{8'h02, 8'h02, 8'h22, 6'h22, 8'h00};  // SUB
    vecs[5] = '{8'h0A, 8'h05, 8'h26, 6'h26, 8'h0F};  // XOR
    vecs[6] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00};  // ADD wraps

    repeat (2) @(negedge clk);
    check("rst_ope1", 32'(alu_ope1), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Byte in WAIT_TX is dropped; then done and a byte in the same cycle.
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h20);
    repeat (2) @(negedge clk);
    send_byte(8'h55);
    check("drop_pulse", 32'(drop), 32'd1);
    check("drop_ope1_kept", 32'(alu_ope1), 32'h11);
    check("drop_still_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("drop_one_cycle", 32'(drop), 32'd0);
    tx_done = 1'b1;
    send_byte(8'h66);
    tx_done = 1'b0;
    check("done_rx_drop", 32'(drop), 32'd1);
    check("done_rx_idle", 32'(busy), 32'd0);
    check("done_rx_ope1_kept", 32'(alu_ope1), 32'h11);
    @(negedge clk);
    tx_done = 1'b1;  // ignored outside WAIT_TX
    @(negedge clk);
    tx_done = 1'b0;
    run_frame(vecs[0]);

    // Asynchronous reset in WAIT_OP discards the partial frame.
    send_byte(8'h11);
    send_byte(8'h22);
    #1 rst = 1'b1;
    #1;
    check("arst_ope1", 32'(alu_ope1), 32'd0);
    check("arst_ope2", 32'(alu_ope2), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("arst_opcode", 32'(alu_opcode), 32'd0);
    check("arst_tx_data", 32'(tx_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    run_frame(vecs[3]);

    // Asynchronous reset while o_tx_start is high.
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h20);
    @(negedge clk);
    check("pre_rst_start", 32'(tx_start), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_start_low", 32'(tx_start), 32'd0);
    check("arst_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef SEQ_TIMEOUT_EN
    // Lone byte then idle: timeout pulse 16 cycles after acceptance.
    send_byte(8'h07);
    seen = 0;
    for (int i = 1; i <= 40; i++) begin
      if (seen == 0 && timeout) seen = i - 1;
      if (seen == 0) @(negedge clk);
    end
    check("timeout_delay", 32'(seen), 32'd16);
    @(negedge clk);
    check("timeout_one_cycle", 32'(timeout), 32'd0);
    check("timeout_ope1_kept", 32'(alu_ope1), 32'h07);
    run_frame(vecs[4]);

    // Byte arriving on the expiry cycle is accepted, no timeout.
    send_byte(8'h09);
    repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
    send_byte(8'h0A);
    check("expiry_no_timeout", 32'(timeout), 32'd0);
    check("expiry_ope2", 32'(alu_ope2), 32'h0A);
    send_byte(8'h20);
    @(negedge clk);
    check("expiry_start", 32'(tx_start), 32'd1);
    check("expiry_result", 32'(tx_data), 32'h13);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
`else
    // Without the timeout a partial frame waits forever in WAIT_B.
    send_byte(8'h07);
    seen = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (timeout || busy) seen++;
    end
    check("no_timeout_idle", 32'(seen), 32'd0);
    send_byte(8'h02);
    send_byte(8'h22);
    check("wait_b_kept_ope1", 32'(alu_ope1), 32'h07);
    @(negedge clk);
    check("wait_b_start", 32'(tx_start), 32'd1);
    check("wait_b_result", 32'(tx_data), 32'h05);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
- Frame sequencer that feeds the 8-bit ALU from a serial byte stream.
- Collects three bytes from the UART receiver (operand 1, operand 2, opcode) and drives them onto the ALU inputs.
- Captures the combinational ALU result and hands it to the UART transmitter with a start/done handshake.
- Sits between the UART RX/TX blocks and the ALU in the top-level.

Parameters:
BUS_LEN, 8, data/operand width; equals the UART byte width.
OPCODE_LEN, 6, ALU opcode width; taken from the low OPCODE_LEN bits of the opcode byte. Requires OPCODE_LEN <= BUS_LEN.
TIMEOUT_CYCLES, 1024, inter-byte timeout in clock cycles. Used only when SEQ_TIMEOUT_EN is defined.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
i_rx_data  in  BUS_LEN  received byte
i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid
i_alu_result  in  BUS_LEN  ALU output (combinational)
o_alu_ope1  out  BUS_LEN  latched operand 1
o_alu_ope2  out  BUS_LEN  latched operand 2
o_alu_opcode  out  OPCODE_LEN  latched opcode
o_tx_data  out  BUS_LEN  captured result for the transmitter
o_tx_start  out  1  one-cycle transmit request
i_tx_done  in  1  one-cycle strobe; transmission finished
o_busy  out  1  high in EXEC, SEND and WAIT_TX
o_drop  out  1  one-cycle pulse when an rx byte is discarded
o_timeout  out  1  one-cycle pulse on frame abort by timeout

Behaviour:
- Reset: state=WAIT_A; all outputs and registers 0. Reset is asynchronous, so asserting it mid-operation immediately deasserts o_tx_start and o_busy and discards any partial frame.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on i_rx_valid, ope1 <= i_rx_data; go to WAIT_B.
- WAIT_B: on i_rx_valid, ope2 <= i_rx_data; go to WAIT_OP.
- WAIT_OP: on i_rx_valid, opcode <= i_rx_data[OPCODE_LEN-1:0]; go to EXEC. The upper byte bits are ignored.
- EXEC: exactly one cycle so the ALU can settle. At the closing edge, o_tx_data <= i_alu_result; go to SEND.
- SEND: o_tx_start=1 for exactly this one cycle (decoded from the state register, glitch-free); go to WAIT_TX.
- WAIT_TX: on i_tx_done, go to WAIT_A. If i_tx_done never arrives, the block waits indefinitely.
- Latency: opcode strobe sampled at edge k -> EXEC during cycle k..k+1 -> o_tx_data valid and o_tx_start high during cycle k+1..k+2.
- Operand/opcode registers hold their values until overwritten by the next frame. o_alu_* always reflect these registers.
- i_rx_valid in EXEC, SEND or WAIT_TX: byte not latched; o_drop pulses for one cycle.
- i_rx_valid and i_tx_done in the same WAIT_TX cycle: go to WAIT_A; the byte is dropped (o_drop=1).
- i_tx_done outside WAIT_TX: ignored.
- o_busy = (state is EXEC, SEND or WAIT_TX).

Optional Feature:
Macro: SEQ_TIMEOUT_EN
- Defined:
  - A counter clears on every accepted byte and counts cycles spent in WAIT_B or WAIT_OP.
  - If TIMEOUT_CYCLES cycles elapse without i_rx_valid, go to WAIT_A and pulse o_timeout for one cycle. Latched operands are kept.
  - If i_rx_valid arrives on the expiry cycle, the byte wins: it is accepted and no timeout is raised.
  - The counter is held at 0 in all other states.
- Not defined: no counter is built; o_timeout is tied to 0; partial frames wait forever. TIMEOUT_CYCLES is unused.

Test Plan:
- Bytes 0x05, 0x03, 0x20 (ADD) with the ALU attached -> o_alu_opcode=0x20; o_tx_data=0x08; o_tx_start high exactly 1 cycle, one cycle after EXEC.
- Bytes 0x80, 0x01, 0x03 (SRA) -> o_tx_data=0xC0. Opcode byte 0xE4 -> o_alu_opcode=0x24 (AND).
- Full frame, then byte 0x55 sent while in WAIT_TX -> o_drop pulses, ope1 unchanged. Pulse i_tx_done together with i_rx_valid -> state WAIT_A, byte dropped.
- Send 0x11, 0x22, assert rst for 2 cycles in WAIT_OP -> all outputs 0, state WAIT_A. Then frame 0x0F, 0xF0, 0x25 (OR) -> o_tx_data=0xFF.
- SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=16: send 0x07, then idle -> o_timeout pulse 16 cycles after acceptance, state WAIT_A. Next frame 0x02, 0x02, 0x22 (SUB) -> 0x00.
- SEQ_TIMEOUT_EN defined: i_rx_valid on the expiry cycle -> byte accepted, no o_timeout. Macro undefined: 5000 idle cycles in WAIT_B -> o_timeout stays 0, state stays WAIT_B.
